uart_frame_rx_ctrl: RTL

Frame-level controller that sits directly after the UART byte receiver and sequences its output stream. It hunts for a sync byte, then parses a length byte, a payload and a checksum byte, buffering the payload internally. Only checksum-verified payloads are released downstream over a valid/ready stream; malformed, stalled or overrunning frames are discarded and flagged.

---
 rtl/uart_frame_rx_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/uart_frame_rx_ctrl.sv
// uart_frame_rx_ctrl: frame sequencer placed after a UART byte receiver.
// It hunts for SYNC_BYTE, then takes a length byte, the payload and a
// checksum byte. The payload is buffered and is released over a
// valid/ready stream only when the checksum matches. Length errors,
// checksum errors, mid-frame idle timeouts and bytes that arrive while a
// payload is draining are each reported as a one-cycle pulse.
module uart_frame_rx_ctrl #(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMER_BITS   = 32,
    parameter int         TIMEOUT_CLKS = 8680
) (
    input  logic       clk,
    input  logic       i_reset_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       err_len,
    output logic       err_csum,
    output logic       err_timeout,
    output logic       err_overrun
);

    localparam int                    IDX_W      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]            MAX_LEN_B  = 8'(MAX_LEN);
    localparam logic [TIMER_BITS-1:0] TIMER_LAST = TIMER_BITS'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_DRAIN
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [7:0]            len;
    logic [7:0]            idx;
    logic [7:0]            sum;
    logic [TIMER_BITS-1:0] timer;
    logic [7:0]            pay_mem [MAX_LEN];

    logic in_frame;
    logic len_bad;
    logic last_idx;
    logic timeout_hit;
    logic handshake;

    // Running checksum: plain 8-bit modular sum.
    function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    assign in_frame    = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
    assign len_bad     = (in_data == 8'd0) || (in_data > MAX_LEN_B);
    assign last_idx    = (idx == len - 8'd1);
    assign timeout_hit = in_frame && !in_valid && (timer == TIMER_LAST);
    assign handshake   = (state == S_DRAIN) && out_ready;

    // State register.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= S_HUNT;
        else            state <= state_nxt;
    end

    // Next-state logic. An arriving byte always takes precedence over the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            S_HUNT: begin
                if (in_valid && (in_data == SYNC_BYTE)) state_nxt = S_LEN;
            end
            S_LEN: begin
                if (in_valid)         state_nxt = len_bad ? S_HUNT : S_PAYLOAD;
                else if (timeout_hit) state_nxt = S_HUNT;
            end
            S_PAYLOAD: begin
                if (in_valid) begin
                    if (last_idx) state_nxt = S_CSUM;
                end else if (timeout_hit) begin
                    state_nxt = S_HUNT;
                end
            end
            S_CSUM: begin
                if (in_valid)         state_nxt = (in_data == sum) ? S_DRAIN : S_HUNT;
                else if (timeout_hit) state_nxt = S_HUNT;
            end
            S_DRAIN: begin
                if (handshake && last_idx) state_nxt = S_HUNT;
            end
            default: state_nxt = S_HUNT;
        endcase
    end

    // Frame bookkeeping (length, index, checksum, idle timer) and error pulses.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            len         <= 8'd0;
            idx         <= 8'd0;
            sum         <= 8'd0;
            timer       <= '0;
            err_len     <= 1'b0;
            err_csum    <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_len     <= (state == S_LEN) && in_valid && len_bad;
            err_csum    <= (state == S_CSUM) && in_valid && (in_data != sum);
            err_timeout <= timeout_hit;
            err_overrun <= (state == S_DRAIN) && in_valid;
            // Timer only runs while a frame is being parsed; any byte restarts it.
            timer <= (in_valid || !in_frame) ? '0 : timer + TIMER_BITS'(1);
            case (state)
                S_LEN: begin
                    if (in_valid && !len_bad) begin
                        len <= in_data;
                        sum <= in_data;
                        idx <= 8'd0;
                    end
                end
                S_PAYLOAD: begin
                    if (in_valid) begin
                        sum <= csum_add(sum, in_data);
                        idx <= idx + 8'd1;
                    end
                end
                S_CSUM: begin
                    if (in_valid) idx <= 8'd0;
                end
                S_DRAIN: begin
                    if (handshake) idx <= idx + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Payload buffer write port; contents need no reset.
    always_ff @(posedge clk) begin
        if ((state == S_PAYLOAD) && in_valid) pay_mem[idx[IDX_W-1:0]] <= in_data;
    end

    // Stream outputs, read combinationally from the buffer at the drain index.
    always_comb begin
        out_valid = (state == S_DRAIN);
        out_data  = pay_mem[idx[IDX_W-1:0]];
        out_last  = (state == S_DRAIN) && last_idx;
    end

endmodule
